// File: rtl/baw_turn_scheduler.sv
// baw_turn_scheduler: Black-and-White round sequencer with debounced buttons; TURN_TIMEOUT_EN enables selection auto-play
module baw_turn_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ROUNDS = 9,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnCenter,
  input  logic       btnTop,
  input  logic       btnBottom,
  input  logic [8:0] sw,
  input  logic [8:0] p1_card,
  input  logic [8:0] p2_card,
  input  logic [1:0] match_result,
  output logic [2:0] phase,
  output logic       active_player,
  output logic       leader,
  output logic       p1_commit,
  output logic       p2_commit,
  output logic [3:0] hand_index,
  output logic       score_update,
  output logic       invalid_sel,
  output logic [3:0] round_cnt,
  output logic       game_over
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    LEAD_SEL   = 3'b001,
    FOLLOW_SEL = 3'b010,
    COMPARE    = 3'b011,
    SHOW       = 3'b100,
    DONE       = 3'b101
  } state_t;
  state_t state;
  logic [2:0] raw, lvl, pls;
  logic [CW-1:0] cnt [3];
  logic bot, top, ctr, sel_ok, tmo, go, bad, cmp2;
  logic [8:0] avail;
  logic [3:0] sw_idx, low_idx, idx;
  assign raw = {btnBottom, btnTop, btnCenter};
  assign phase = state;
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      lvl <= '0;
      pls <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pls[i] <= 1'b0;
        if (raw[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= raw[i];
          pls[i] <= raw[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  assign bot = pls[2];
  assign top = pls[1] & ~pls[2];
  assign ctr = pls[0] & ~|pls[2:1];
  always_comb begin
    avail = active_player ? p2_card : p1_card;
    sel_ok = sw != 9'd0 && (sw & (sw - 9'd1)) == 9'd0 && (sw & avail) != 9'd0;
    sw_idx = 4'd0;
    low_idx = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      sw_idx = sw[i] ? 4'(i) : sw_idx;
      low_idx = avail[i] ? 4'(i) : low_idx;
    end
    go = top ? sel_ok : tmo && avail != 9'd0;
    bad = top ? !sel_ok : tmo && avail == 9'd0;
    idx = top ? sw_idx : low_idx;
  end
`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic sel_phase;
  assign sel_phase = state == LEAD_SEL || state == FOLLOW_SEL;
  assign tmo = sel_phase && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || bot || top || tmo || !sel_phase) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      leader <= 1'b0;
      active_player <= 1'b0;
      p1_commit <= 1'b0;
      p2_commit <= 1'b0;
      hand_index <= 4'd0;
      score_update <= 1'b0;
      invalid_sel <= 1'b0;
      round_cnt <= 4'd0;
      game_over <= 1'b0;
      cmp2 <= 1'b0;
    end else begin
      p1_commit <= 1'b0;
      p2_commit <= 1'b0;
      score_update <= 1'b0;
      if (bot) begin
        state <= IDLE;
        round_cnt <= 4'd0;
        leader <= 1'b0;
        active_player <= 1'b0;
        invalid_sel <= 1'b0;
        game_over <= 1'b0;
        cmp2 <= 1'b0;
      end else case (state)
        IDLE: if (ctr) begin
          state <= LEAD_SEL;
          active_player <= leader;
        end
        LEAD_SEL, FOLLOW_SEL: if (go) begin
          p1_commit <= !active_player;
          p2_commit <= active_player;
          hand_index <= idx;
          invalid_sel <= 1'b0;
          active_player <= state == LEAD_SEL ? !active_player : active_player;
          state <= state == LEAD_SEL ? FOLLOW_SEL : COMPARE;
        end else if (bad) invalid_sel <= 1'b1;
        COMPARE: begin
          cmp2 <= !cmp2;
          if (cmp2) begin
            score_update <= 1'b1;
            round_cnt <= round_cnt == 4'(ROUNDS) ? round_cnt : round_cnt + 4'd1;
            leader <= match_result == 2'b01 ? 1'b0 : match_result == 2'b10 ? 1'b1 : leader;
            state <= SHOW;
          end
        end
        SHOW: if (ctr) begin
          state <= round_cnt == 4'(ROUNDS) ? DONE : LEAD_SEL;
          game_over <= round_cnt == 4'(ROUNDS);
          active_player <= leader;
        end
        default: ;
      endcase
    end
endmodule

// File: doc/baw_turn_scheduler.md
Name: baw_turn_scheduler

Overview:
- Sequences one Black-and-White round between two players.
- Conditions raw pushbuttons: debounce plus rising-edge pulse.
- Decides the lead player for each round and validates each card selection against the player's remaining cards.
- Issues one-cycle commit pulses to the hand-card registers and a score-update pulse to the scoring datapath. Counts rounds to game end.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles before a debounced button level changes.
- ROUNDS, 9: rounds per game.
- TIMEOUT_CYCLES, 1000000000: idle cycles in a selection phase before auto-play. Used only with TURN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btnCenter  in  1  raw button: start / advance
- btnTop  in  1  raw button: confirm selection
- btnBottom  in  1  raw button: abort to idle
- sw  in  9  one-hot card selection, bit k = card k
- p1_card  in  9  P1 remaining cards, 1 = available
- p2_card  in  9  P2 remaining cards
- match_result  in  2  comparator output: 01 = P1 wins, 10 = P2 wins, 00 = draw
- phase  out  3  000 IDLE, 001 LEAD_SEL, 010 FOLLOW_SEL, 011 COMPARE, 100 SHOW, 101 DONE
- active_player  out  1  0 = P1, 1 = P2; player currently selecting
- leader  out  1  player who leads the current round
- p1_commit  out  1  one-cycle pulse: latch P1 hand card, remove it from p1_card
- p2_commit  out  1  one-cycle pulse: latch P2 hand card
- hand_index  out  4  encoded card index 0..8; valid during a commit pulse
- score_update  out  1  one-cycle pulse to the scoring datapath
- invalid_sel  out  1  last confirm was rejected
- round_cnt  out  4  completed rounds, 0..ROUNDS
- game_over  out  1  high in DONE

Behaviour:
- Reset values: phase = IDLE; leader, active_player, commits, score_update, invalid_sel, round_cnt, game_over all 0; hand_index = 0; debouncers cleared to level 0.
- Debounce: the debounced level follows the raw level only after DEBOUNCE_CYCLES consecutive equal samples. A press pulse lasts one cycle, on the debounced 0→1 edge.
- Pulse priority on simultaneous pulses: bottom > top > center. Only the highest-priority pulse acts.
- bottom pulse, any state: phase = IDLE, round_cnt = 0, leader = P1, invalid_sel = 0. No commit or score pulse is issued that cycle.
- IDLE: center pulse → LEAD_SEL; active_player = leader.
- Valid selection: sw is exactly one-hot AND the selected bit is set in the active player's card vector.
- LEAD_SEL / FOLLOW_SEL, top pulse in cycle N:
  - Valid: in cycle N+1, the matching commit pulse fires, hand_index = bit position, invalid_sel = 0. LEAD_SEL → FOLLOW_SEL with active_player toggled; FOLLOW_SEL → COMPARE.
  - Invalid (zero or multiple bits, or a card already spent): invalid_sel = 1, stay in the phase, no pulse.
- COMPARE lasts exactly 2 cycles, letting the hand-card registers and the comparator settle.
  - Cycle 2: score_update = 1, match_result is registered, round_cnt increments.
  - Then → SHOW.
- Next leader: 01 → P1, 10 → P2, 00 → unchanged.
- SHOW: center pulse → DONE if round_cnt == ROUNDS, else LEAD_SEL with active_player = new leader.
- DONE: game_over = 1. Only a bottom pulse exits.
- center or top pulses in phases where they have no meaning are ignored.
- round_cnt never exceeds ROUNDS; no wrap-around.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Enabled: in LEAD_SEL / FOLLOW_SEL, a counter clears on phase entry and on every top pulse.
  - On reaching TIMEOUT_CYCLES, the block auto-commits the lowest-index available card of the active player, exactly as a valid confirm would.
  - If the player's card vector is 0, it stays and raises invalid_sel.
- Disabled: no counter is instantiated; the block waits indefinitely.

Test Plan:
- Bench uses DEBOUNCE_CYCLES = 4. btnTop held high for 3 cycles, then low → no pulse, state unchanged. Held for 5 cycles → exactly one pulse.
- Reset, center, LEAD_SEL with sw = 9'b000010000, p1_card = 9'h1FF, top → p1_commit for 1 cycle, hand_index = 4, phase = FOLLOW_SEL, active_player = 1.
- FOLLOW_SEL with sw = 9'b000000011, then sw = 9'b000010000 with p2_card bit 4 = 0, top each time → invalid_sel = 1, no p2_commit, phase stays 010.
- Complete round with match_result = 10 → score_update exactly once, 2 cycles after p2_commit; round_cnt = 1; after center, leader = 1 and active_player = 1. Next round with draw 00 → leader stays 1.
- Play 9 valid rounds → after the ninth SHOW plus center: phase = DONE, game_over = 1, round_cnt = 9. Further center/top ignored; bottom → IDLE, round_cnt = 0, leader = 0.
- Top and bottom pulse in the same cycle during LEAD_SEL → IDLE, no commit pulse.
- With TURN_TIMEOUT_EN and TIMEOUT_CYCLES = 20, p1_card = 9'b101000000, no confirm → p1_commit at cycle 20 after entry, hand_index = 6.
